serializador_tx: RTL and testbench

Transmit-side serializer that feeds the 9-bit deserializer. It accepts one parallel byte plus its control flag (`in_DK`) through a valid/ready handshake. It emits each word as a 9-bit serial frame on `data`, one bit per clock, with a one-cycle frame marker on `DK`. After reset, and whenever no word is pending, it transmits idle comma frames (K=1, 0xBC) so the downstream deserializer can align and stay locked.

---
 rtl/serdes_pkg.sv | 18 +
 rtl/serdes_hold_buf.sv | 68 ++++++
 rtl/serializador_tx.sv | 190 +++++++++++++++++++
 tb/tb_serializador_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// ---------------------------------------------------------------------------
// serdes_pkg
// Constants shared by the 9-bit serializer and its matching deserializer:
// frame width, idle comma code, idle K flag and the link-up state encoding.
// ---------------------------------------------------------------------------
package serdes_pkg;

    localparam int          PAYLOAD_W = 8;
    localparam int          FW        = PAYLOAD_W + 1;
    localparam logic [7:0]  IDLE_CODE = 8'hBC;
    localparam logic        IDLE_K    = 1'b1;

    typedef enum logic [0:0] {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } serdes_state_e;

endpackage : serdes_pkg

// File: rtl/serdes_hold_buf.sv
// ---------------------------------------------------------------------------
// serdes_hold_buf
// One-entry holding buffer with valid/ready on the write side. A word may be
// pushed while full only when the owner signals that the entry is being
// drained on the same edge (drain_ok_i), which gives bubble-free transfers.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push_valid_i    writer offers push_data_i
//   push_data_i     word to store
//   push_ready_o    entry can take a word this cycle
//   drain_ok_i      owner pops the entry on this edge if it is full
//   pop_i           owner takes the stored word on this edge
//   full_o          entry holds a word
//   pop_data_o      stored word
// ---------------------------------------------------------------------------
module serdes_hold_buf #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_valid_i,
    input  logic [W-1:0] push_data_i,
    output logic         push_ready_o,
    input  logic         drain_ok_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic [W-1:0] pop_data_o
);

    logic         full_q;
    logic         full_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;
    logic         push_s;

    assign push_ready_o = !full_q || drain_ok_i;
    assign push_s       = push_valid_i && push_ready_o;
    assign full_o       = full_q;
    assign pop_data_o   = data_q;

    // Next buffer contents: a push wins over a pop, so full stays set when
    // the entry is drained and refilled on the same edge.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (push_s) begin
            full_d = 1'b1;
            data_d = push_data_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Buffer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule : serdes_hold_buf

// File: rtl/serializador_tx.sv
// ---------------------------------------------------------------------------
// serializador_tx
// Transmit serializer for the 9-bit link. Parallel words (payload + K flag)
// enter through valid/ready, go through a one-entry holding buffer and are
// sent MSB-first as FW-bit frames: K flag first, then in[BITS-1]..in[0].
// DK marks the cycle carrying the K bit. Idle comma frames fill every slot
// without a pending word, and IDLE_FRAMES of them are forced after reset so
// the receiver can lock before payload arrives.
//
// Ports:
//   clk       clock
//   reset     asynchronous active-high reset
//   in        payload word
//   in_DK     K flag of the payload word (1 = control symbol)
//   valid_in  in/in_DK hold a word to send
//   ready     a word offered this cycle is accepted on the next edge
//   data      serial bit stream (registered)
//   DK        frame marker, high with the K bit (registered)
// ---------------------------------------------------------------------------
module serializador_tx #(
    parameter int BITS        = 8,
    parameter int IDLE_FRAMES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] in,
    input  logic            in_DK,
    input  logic            valid_in,
    output logic            ready,
    output logic            data,
    output logic            DK
);

    import serdes_pkg::*;

    localparam int                  FRAME_W   = BITS + 1;
    localparam int                  CNT_W     = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(FRAME_W - 1);
    localparam int                  IDLE_W    = $clog2(IDLE_FRAMES + 2);
    localparam logic [IDLE_W-1:0]   IDLE_LAST = IDLE_W'(IDLE_FRAMES);
    localparam logic [BITS-1:0]     IDLE_WORD = BITS'(IDLE_CODE);

    serdes_state_e        state_q;
    serdes_state_e        state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [IDLE_W-1:0]    idle_cnt_q;
    logic [IDLE_W-1:0]    idle_cnt_d;
    logic [FRAME_W-1:0]   shreg_q;
    logic [FRAME_W-1:0]   shreg_d;
    logic                 data_q;
    logic                 data_d;
    logic                 dk_q;
    logic                 dk_d;

    logic                 boundary_s;
    logic                 warm_done_s;
    logic                 drain_ok_s;
    logic                 load_buf_s;
    logic                 count_idle_s;
    logic                 buf_full_s;
    logic [FRAME_W-1:0]   buf_word_s;
    logic [FRAME_W-1:0]   next_frame_s;

    assign boundary_s  = (cnt_q == CNT_LAST);
    assign warm_done_s = (idle_cnt_q == IDLE_LAST);
    // Only a RUN boundary lets a full buffer take a new word; the last
    // WARMUP boundary drains the buffer but keeps ready low.
    assign drain_ok_s  = (state_q == RUN) && boundary_s;

    serdes_hold_buf #(
        .W (FRAME_W)
    ) u_hold_buf (
        .clk          (clk),
        .reset        (reset),
        .push_valid_i (valid_in),
        .push_data_i  ({in_DK, in}),
        .push_ready_o (ready),
        .drain_ok_i   (drain_ok_s),
        .pop_i        (load_buf_s),
        .full_o       (buf_full_s),
        .pop_data_o   (buf_word_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WARMUP;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave WARMUP at the boundary that would load idle
    // frame IDLE_FRAMES+1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WARMUP: begin
                if (boundary_s && warm_done_s) begin
                    state_d = RUN;
                end else begin
                    state_d = WARMUP;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = WARMUP;
        endcase
    end

    // FSM outputs: which frame source the next boundary uses, and whether
    // that boundary counts as a forced idle frame.
    always_comb begin
        load_buf_s   = 1'b0;
        count_idle_s = 1'b0;
        case (state_q)
            WARMUP: begin
                load_buf_s   = boundary_s && warm_done_s && buf_full_s;
                count_idle_s = boundary_s && !warm_done_s;
            end
            RUN: begin
                load_buf_s   = boundary_s && buf_full_s;
                count_idle_s = 1'b0;
            end
            default: begin
                load_buf_s   = 1'b0;
                count_idle_s = 1'b0;
            end
        endcase
    end

    // Frame selection: buffered word or idle comma.
    always_comb begin
        next_frame_s = {IDLE_K, IDLE_WORD};
        if (load_buf_s) begin
            next_frame_s = buf_word_s;
        end else begin
            next_frame_s = {IDLE_K, IDLE_WORD};
        end
    end

    // Shifter next state. At a boundary the K bit goes straight to the
    // output register and the rest of the frame is parked in the shifter,
    // so bit k is on data during cycle k after the load edge.
    always_comb begin
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        dk_d       = dk_q;
        idle_cnt_d = idle_cnt_q;
        if (boundary_s) begin
            cnt_d   = '0;
            shreg_d = {next_frame_s[FRAME_W-2:0], 1'b0};
            data_d  = next_frame_s[FRAME_W-1];
            dk_d    = 1'b1;
        end else begin
            cnt_d   = cnt_q + 1'b1;
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            data_d  = shreg_q[FRAME_W-1];
            dk_d    = 1'b0;
        end
        if (count_idle_s) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
            idle_cnt_d = idle_cnt_q;
        end
    end

    // Shifter, counters and output registers. cnt resets to the last
    // position so the first edge after reset loads a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= CNT_LAST;
            idle_cnt_q <= '0;
            shreg_q    <= '0;
            data_q     <= 1'b0;
            dk_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idle_cnt_q <= idle_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            dk_q       <= dk_d;
        end
    end

    assign data = data_q;
    assign DK   = dk_q;

endmodule : serializador_tx

// File: tb/tb_serializador_tx.sv
// ---------------------------------------------------------------------------
// tb_serializador_tx
// Directed bench for serializador_tx. A frame decoder turns the serial
// stream into {K, byte} words; the main sequence checks them and the
// handshake against hand-computed values.
// ---------------------------------------------------------------------------
module tb_serializador_tx;

    localparam logic [8:0] IDLE_F = 9'h1BC;

    logic       clk;
    logic       reset;
    logic [7:0] in;
    logic       in_DK;
    logic       valid_in;
    logic       ready;
    logic       data;
    logic       DK;

    int n_assert = 0;
    int n_fail   = 0;

    serializador_tx #(
        .BITS        (8),
        .IDLE_FRAMES (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .in_DK    (in_DK),
        .valid_in (valid_in),
        .ready    (ready),
        .data     (data),
        .DK       (DK)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame decoder: collects 9 bits starting at each DK pulse and records
    // any DK spacing other than 9 cycles.
    logic [8:0] frames[$];
    logic [8:0] cur_q   = 9'h000;
    int         nb_q    = 0;
    int         since_q = 0;
    logic       seen_q  = 1'b0;
    int         gap_err = 0;

    always @(negedge clk) begin
        if (reset) begin
            nb_q   <= 0;
            seen_q <= 1'b0;
        end else if (DK) begin
            if (seen_q && since_q != 8) gap_err <= gap_err + 1;
            seen_q  <= 1'b1;
            since_q <= 0;
            cur_q   <= {8'h00, data};
            nb_q    <= 1;
        end else begin
            since_q <= since_q + 1;
            if (nb_q == 8) begin
                frames.push_back({cur_q[7:0], data});
                nb_q <= 0;
            end else if (nb_q > 0) begin
                cur_q <= {cur_q[7:0], data};
                nb_q  <= nb_q + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 600 && frames.size() < n; i++) @(negedge clk);
        chk("wait_frames", 32'(frames.size() >= n), 32'd1);
    endtask

    function automatic logic [8:0] frame_at(input int i);
        if (i < frames.size()) return frames[i];
        else return 9'h000;
    endfunction

    logic [8:0] words[5];
    int         low_cnt[5];
    int         base;
    int         rd;
    int         idx;
    int         low;
    logic       r;
    logic       found;

    initial begin
        words[0] = 9'h001; words[1] = 9'h0FF; words[2] = 9'h13C;
        words[3] = 9'h0A5; words[4] = 9'h100;
        reset = 1'b1; valid_in = 1'b1; in = 8'h55; in_DK = 1'b0;

        // Reset values, with valid_in high being ignored.
        @(negedge clk);
        chk("rst_data", data, 1'b0);
        chk("rst_dk", DK, 1'b0);
        chk("rst_ready", ready, 1'b1);
        @(negedge clk);
        chk("rst_ready_hold", ready, 1'b1);

        // Idle stream after release.
        reset = 1'b0; valid_in = 1'b0;
        base = frames.size();
        @(negedge clk);
        chk("first_dk", DK, 1'b1);
        chk("first_kbit", data, 1'b1);
        @(negedge clk);
        chk("bit1_dk", DK, 1'b0);
        chk("bit1_data", data, 1'b1);
        repeat (58) @(negedge clk);
        wait_frames(base + 6);
        for (int i = 0; i < 6; i++) chk($sformatf("idle_%0d", i), frame_at(base + i), IDLE_F);
        chk("dk_period", gap_err, 0);

        // Word offered during WARMUP.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = frames.size();
        repeat (3) @(negedge clk);
        chk("warm_ready", ready, 1'b1);
        valid_in = 1'b1; in = 8'h5A; in_DK = 1'b0;
        @(negedge clk);
        valid_in = 1'b0; in = 8'hFF; in_DK = 1'b1;
        chk("warm_ready_low", ready, 1'b0);
        repeat (20) @(negedge clk);
        chk("warm_ready_still_low", ready, 1'b0);
        wait_frames(base + 5);
        for (int i = 0; i < 4; i++) chk($sformatf("warm_idle_%0d", i), frame_at(base + i), IDLE_F);
        chk("warm_payload", frame_at(base + 4), 9'h05A);
        chk("run_ready", ready, 1'b1);
        rd = base + 5;

        // Back-to-back words with valid_in held high.
        idx = 0; low = 0;
        valid_in = 1'b1; {in_DK, in} = words[0];
        for (int c = 0; c < 200 && idx < 5; c++) begin
            r = ready;
            @(negedge clk);
            if (r) begin
                low_cnt[idx] = low;
                low = 0;
                idx++;
                if (idx < 5) {in_DK, in} = words[idx];
                else valid_in = 1'b0;
            end else begin
                low++;
            end
        end
        valid_in = 1'b0;
        chk("b2b_all_accepted", idx, 5);
        chk("b2b_first_wait", 32'(low_cnt[1] <= 8), 32'd1);
        for (int i = 2; i < 5; i++) chk($sformatf("ready_low_%0d", i), low_cnt[i], 8);
        repeat (40) @(negedge clk);
        while (rd < frames.size() && frames[rd] == IDLE_F) rd++;
        for (int i = 0; i < 5; i++) chk($sformatf("b2b_frame_%0d", i), frame_at(rd + i), words[i]);
        chk("b2b_after_idle", frame_at(rd + 5), IDLE_F);

        // Reset in the middle of a payload frame, with a word buffered.
        chk("pre_rst_ready", ready, 1'b1);
        valid_in = 1'b1; in = 8'hF0; in_DK = 1'b0;
        @(negedge clk);
        valid_in = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            if (DK && !data) found = 1'b1;
        end
        chk("payload_start_seen", found, 1'b1);
        chk("buf_ready_k0", ready, 1'b1);
        valid_in = 1'b1; in = 8'h77; in_DK = 1'b0;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("bit3_data", data, 1'b1);
        @(negedge clk);
        chk("bit4_data", data, 1'b1);
        #2;
        reset = 1'b1; valid_in = 1'b1; in = 8'h55;
        #1;
        chk("async_rst_data", data, 1'b0);
        chk("async_rst_dk", DK, 1'b0);
        chk("async_rst_ready", ready, 1'b1);
        repeat (2) @(negedge clk);
        chk("rst_hold_data", data, 1'b0);
        reset = 1'b0; valid_in = 1'b1; in = 8'h81; in_DK = 1'b0;
        base = frames.size();
        @(negedge clk);
        valid_in = 1'b0;
        chk("rerun_first_dk", DK, 1'b1);
        wait_frames(base + 6);
        for (int i = 0; i < 4; i++) chk($sformatf("rerun_idle_%0d", i), frame_at(base + i), IDLE_F);
        chk("rerun_payload", frame_at(base + 4), 9'h081);
        chk("rerun_no_stale", frame_at(base + 5), IDLE_F);
        chk("dk_period_end", gap_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_serializador_tx
